// File: rtl/sw_debounce_sync.sv
`default_nettype none
// ============================================================================
// Module   : sw_debounce_sync
// Brief    : Per-channel switch synchronizer, debouncer, edge detector and
//            sticky request flag with consumer acknowledge.
// Revision : 1.0 - initial release
// ============================================================================

module sw_debounce_sync #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 1000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] sw_in,
    input  logic [N_CH-1:0] ack,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] pend
);

    localparam int                 c_CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_TERM  = c_CNT_W'(DEB_CYCLES - 1);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [c_CNT_W-1:0]     r_cnt;
        logic                   r_level;
        logic                   r_rise;
        logic                   r_fall;
        logic                   r_pend;
        logic                   w_sync_q;
        logic                   w_diff;
        logic                   w_term;

        assign w_sync_q = r_sync[SYNC_STAGES-1];
        assign w_diff   = (w_sync_q != r_level);
        assign w_term   = w_diff && (r_cnt == c_TERM);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], sw_in[i]};
            end
        end

        // Any agreement between sync_q and level discards partial progress.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_rise <= w_term &&  w_sync_q;
                r_fall <= w_term && !w_sync_q;
                if (!w_diff || w_term) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_term) begin
                    r_level <= w_sync_q;
                end
            end
        end

        // A new rise takes priority over a simultaneous acknowledge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pend <= 1'b0;
            end else begin
                r_pend <= r_rise || (r_pend && !ack[i]);
            end
        end

        assign level[i] = r_level;
        assign rise[i]  = r_rise;
        assign fall[i]  = r_fall;
        assign pend[i]  = r_pend;
    end

endmodule

`default_nettype wire

// File: tb/tb_sw_debounce_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_debounce_sync
// Brief    : Directed self-checking bench for sw_debounce_sync
//            (DEB_CYCLES=4, SYNC_STAGES=2, N_CH=4).
// Revision : 1.0 - initial release
// ============================================================================

module tb_sw_debounce_sync;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw_in;
    logic [3:0] ack;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] pend;

    int total;
    int bad;

    sw_debounce_sync #(
        .N_CH        (4),
        .SYNC_STAGES (2),
        .DEB_CYCLES  (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw_in (sw_in),
        .ack   (ack),
        .level (level),
        .rise  (rise),
        .fall  (fall),
        .pend  (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sw_in = 4'b0000;
        ack   = 4'b0000;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sw_in = 4'b0000;
        ack   = 4'b0000;
        #3;
        total++;
        if ({level, rise, fall, pend} !== 16'h0000) begin
            bad++;
            $display("FAIL reset_hold: got l=%b r=%b f=%b p=%b expected all 0", level, rise, fall, pend);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if ({level, rise, fall, pend} !== 16'h0000) begin
            bad++;
            $display("FAIL reset_release: got l=%b r=%b f=%b p=%b expected all 0", level, rise, fall, pend);
        end
    endtask

    task automatic test_clean_press();
        sw_in[0] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            total++;
            if (level[0] !== (e >= 6) || rise[0] !== (e == 6) || pend[0] !== (e >= 7)) begin
                bad++;
                $display("FAIL clean_press edge %0d: got l=%b r=%b p=%b expected l=%b r=%b p=%b",
                         e, level[0], rise[0], pend[0], (e >= 6), (e == 6), (e >= 7));
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] pat;
        pat = 4'b0101;
        for (int b = 0; b < 4; b++) begin
            sw_in[1] = pat[b];
            tick();
            total++;
            if (rise[1] !== 1'b0 || level[1] !== 1'b0) begin
                bad++;
                $display("FAIL bounce_quiet step %0d: got r=%b l=%b expected r=0 l=0", b, rise[1], level[1]);
            end
        end
        sw_in[1] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            total++;
            if (rise[1] !== (e == 6) || level[1] !== (e >= 6)) begin
                bad++;
                $display("FAIL bounce_hold edge %0d: got r=%b l=%b expected r=%b l=%b",
                         e, rise[1], level[1], (e == 6), (e >= 6));
            end
        end
    endtask

    task automatic test_ack();
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        total++;
        if (pend[1:0] !== 2'b10) begin
            bad++;
            $display("FAIL ack_clear: got pend[1:0]=%b expected 10", pend[1:0]);
        end
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        total++;
        if (pend[0] !== 1'b0 || level[0] !== 1'b1) begin
            bad++;
            $display("FAIL ack_idle: got p=%b l=%b expected p=0 l=1", pend[0], level[0]);
        end
        sw_in[0] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            total++;
            if (fall[0] !== (e == 6) || pend[0] !== 1'b0) begin
                bad++;
                $display("FAIL ack_release edge %0d: got f=%b p=%b expected f=%b p=0", e, fall[0], pend[0], (e == 6));
            end
        end
        ack[0]   = 1'b1;
        sw_in[0] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            total++;
            if (rise[0] !== (e == 6) || pend[0] !== (e == 7)) begin
                bad++;
                $display("FAIL ack_set_wins edge %0d: got r=%b p=%b expected r=%b p=%b",
                         e, rise[0], pend[0], (e == 6), (e == 7));
            end
        end
        ack[0] = 1'b0;
        tick();
        total++;
        if (pend[0] !== 1'b1) begin
            bad++;
            $display("FAIL ack_after_set: got p=%b expected 1", pend[0]);
        end
    endtask

    task automatic test_release();
        sw_in[2] = 1'b1;
        for (int e = 1; e <= 7; e++) tick();
        total++;
        if (level[2] !== 1'b1 || pend[2] !== 1'b1) begin
            bad++;
            $display("FAIL release_setup: got l=%b p=%b expected l=1 p=1", level[2], pend[2]);
        end
        sw_in[2] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            total++;
            if (fall[2] !== (e == 6) || rise[2] !== 1'b0 || level[2] !== (e < 6) || pend[2] !== 1'b1) begin
                bad++;
                $display("FAIL release edge %0d: got f=%b r=%b l=%b p=%b expected f=%b r=0 l=%b p=1",
                         e, fall[2], rise[2], level[2], pend[2], (e == 6), (e < 6));
            end
        end
    endtask

    task automatic test_async_reset();
        sw_in[3] = 1'b1;
        for (int e = 1; e <= 4; e++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({level, rise, fall, pend} !== 16'h0000) begin
            bad++;
            $display("FAIL async_reset: got l=%b r=%b f=%b p=%b expected all 0", level, rise, fall, pend);
        end
        sw_in = 4'b1000;
        tick();
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            total++;
            if (rise !== ((e == 6) ? 4'b1000 : 4'b0000) || fall !== 4'b0000) begin
                bad++;
                $display("FAIL async_rerise edge %0d: got r=%b f=%b expected r=%b f=0000",
                         e, rise, fall, (e == 6) ? 4'b1000 : 4'b0000);
            end
        end
    endtask

    task automatic test_independence();
        logic [3:0] pat [1:4];
        logic [3:0] exp_rise;
        pat[1] = 4'b1111;
        pat[2] = 4'b1001;
        pat[3] = 4'b0111;
        pat[4] = 4'b1011;
        for (int e = 1; e <= 12; e++) begin
            sw_in = (e <= 4) ? pat[e] : 4'b1111;
            tick();
            case (e)
                6:       exp_rise = 4'b0001;
                8:       exp_rise = 4'b0010;
                9:       exp_rise = 4'b1000;
                10:      exp_rise = 4'b0100;
                default: exp_rise = 4'b0000;
            endcase
            total++;
            if (rise !== exp_rise || fall !== 4'b0000) begin
                bad++;
                $display("FAIL independence edge %0d: got r=%b f=%b expected r=%b f=0000", e, rise, fall, exp_rise);
            end
        end
        total++;
        if (level !== 4'b1111 || pend !== 4'b1111) begin
            bad++;
            $display("FAIL independence_final: got l=%b p=%b expected 1111 1111", level, pend);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        sw_in = 4'b0000;
        ack   = 4'b0000;
        rst_n = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_ack();
        test_release();
        test_async_reset();
        do_reset();
        test_independence();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
